// File: rtl/pdua_shift_acc_unit.sv
// Multi-cycle shift/rotate accumulator for the PDUA datapath with C/N/P/Z flag update.
// Define SHIFT_BARREL_EN to use a combinational barrel shifter instead of the serial datapath.
module pdua_shift_acc_unit #(
    parameter int MAX_WIDTH   = 8,
    parameter int SHAMT_WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [2:0]             selop,
    input  logic [SHAMT_WIDTH-1:0] shamt,
    input  logic                   enaf,
    input  logic [MAX_WIDTH-1:0]   din,
    output logic                   busy,
    output logic                   done,
    output logic [MAX_WIDTH-1:0]   dout,
    output logic                   C,
    output logic                   N,
    output logic                   P,
    output logic                   Z
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [2:0] OP_SLL = 3'd0;
    localparam logic [2:0] OP_SRL = 3'd1;
    localparam logic [2:0] OP_SRA = 3'd2;
    localparam logic [2:0] OP_ROL = 3'd3;
    localparam logic [2:0] OP_ROR = 3'd4;

    logic [1:0]             state;
    logic [MAX_WIDTH-1:0]   acc;
    logic [SHAMT_WIDTH-1:0] cnt;
    logic [2:0]             mode;
    logic                   enaf_l;
    logic                   carry_tmp;

    function automatic logic is_pass(input logic [2:0] op);
        return op > OP_ROR;
    endfunction

    // One 1-bit step; result is {bit leaving the word, shifted word}.
    function automatic logic [MAX_WIDTH:0] step1(input logic [MAX_WIDTH-1:0] a, input logic [2:0] op);
        case (op)
            OP_SLL:  step1 = {a[MAX_WIDTH-1], a[MAX_WIDTH-2:0], 1'b0};
            OP_SRL:  step1 = {a[0], 1'b0, a[MAX_WIDTH-1:1]};
            OP_SRA:  step1 = {a[0], a[MAX_WIDTH-1], a[MAX_WIDTH-1:1]};
            OP_ROL:  step1 = {a[MAX_WIDTH-1], a[MAX_WIDTH-2:0], a[MAX_WIDTH-1]};
            OP_ROR:  step1 = {a[0], a[0], a[MAX_WIDTH-1:1]};
            default: step1 = {1'b0, a};
        endcase
    endfunction

`ifdef SHIFT_BARREL_EN
    localparam int unsigned MAX_SHIFT = (1 << SHAMT_WIDTH) - 1;
    logic [MAX_WIDTH:0] barrel;

    always_comb begin
        barrel = {1'b0, din};
        if (!is_pass(selop)) begin
            for (int unsigned i = 0; i < MAX_SHIFT; i++) begin
                if (i < 32'(shamt)) barrel = step1(barrel[MAX_WIDTH-1:0], selop);
            end
        end
    end
`endif

    assign dout = acc;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            acc       <= '0;
            cnt       <= '0;
            mode      <= '0;
            enaf_l    <= 1'b0;
            carry_tmp <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            C         <= 1'b0;
            N         <= 1'b0;
            P         <= 1'b0;
            Z         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mode   <= selop;
                        enaf_l <= enaf;
                        busy   <= 1'b1;
                        state  <= ST_SHIFT;
`ifdef SHIFT_BARREL_EN
                        // Full result lands now; the single pass through SHIFT with cnt==0
                        // only places done at edge 1 regardless of shamt.
                        acc       <= barrel[MAX_WIDTH-1:0];
                        carry_tmp <= barrel[MAX_WIDTH];
                        cnt       <= '0;
`else
                        acc       <= din;
                        carry_tmp <= 1'b0;
                        cnt       <= shamt;
`endif
                    end
                end
                ST_SHIFT: begin
                    if (cnt == '0 || is_pass(mode)) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        if (enaf_l) begin
                            C <= carry_tmp;
                            N <= acc[MAX_WIDTH-1];
                            P <= ~^acc;
                            Z <= (acc == '0);
                        end
                    end else begin
                        {carry_tmp, acc} <= step1(acc, mode);
                        cnt              <= cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pdua_shift_acc_unit.sv
// Directed self-checking bench for pdua_shift_acc_unit (MAX_WIDTH=8, SHAMT_WIDTH=3).
module tb_pdua_shift_acc_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [2:0] selop = '0;
    logic [2:0] shamt = '0;
    logic       enaf = 1'b0;
    logic [7:0] din = '0;
    logic       busy, done, C, N, P, Z;
    logic [7:0] dout;

    int checks = 0;
    int errors = 0;

`ifdef SHIFT_BARREL_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    pdua_shift_acc_unit #(.MAX_WIDTH(8), .SHAMT_WIDTH(3)) dut (
        .clk(clk), .rst(rst), .start(start), .selop(selop), .shamt(shamt),
        .enaf(enaf), .din(din), .busy(busy), .done(done), .dout(dout),
        .C(C), .N(N), .P(P), .Z(Z)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int lat(input int sh);
        return BARREL ? 1 : sh + 1;
    endfunction

    // Drives a request so it is sampled at the next edge (edge 0).
    task automatic start_op(input logic [2:0] s, input logic [7:0] d, input logic [2:0] sh, input logic ef);
        selop = s; din = d; shamt = sh; enaf = ef; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int from_edge, input int exp_edge);
        int e;
        e = from_edge;
        while (done !== 1'b1 && e < from_edge + 20) begin
            tick();
            e++;
        end
        check({tag, " done_edge"}, 8'(e), 8'(exp_edge));
        check({tag, " busy_at_done"}, {7'b0, busy}, 8'h01);
    endtask

    task automatic check_res(input string tag, input logic [7:0] d, input logic c, input logic n, input logic p, input logic z);
        check({tag, " dout"}, dout, d);
        check({tag, " CNPZ"}, {4'b0, C, N, P, Z}, {4'b0, c, n, p, z});
    endtask

    task automatic finish_op(input string tag);
        tick();
        check({tag, " busy_clear"}, {7'b0, busy}, 8'h00);
        check({tag, " done_clear"}, {7'b0, done}, 8'h00);
    endtask

    initial begin
        // reset state
        rst = 1'b0;
        tick();
        tick();
        check("reset busy", {7'b0, busy}, 8'h00);
        check("reset done", {7'b0, done}, 8'h00);
        check_res("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();

        // SLL 0x81 by 2
        start_op(3'b000, 8'h81, 3'd2, 1'b1);
        check("sll busy_after_start", {7'b0, busy}, 8'h01);
        wait_done("sll", 0, lat(2));
        check_res("sll", 8'h04, 1'b0, 1'b0, 1'b0, 1'b0);
        finish_op("sll");

        // SRA 0x90 by 3
        start_op(3'b010, 8'h90, 3'd3, 1'b1);
        wait_done("sra", 0, lat(3));
        check_res("sra", 8'hF2, 1'b0, 1'b1, 1'b0, 1'b0);
        finish_op("sra");

        // ROR 0x01 by 1 then SLL 0x80 by 1
        start_op(3'b100, 8'h01, 3'd1, 1'b1);
        wait_done("ror", 0, lat(1));
        check_res("ror", 8'h80, 1'b1, 1'b1, 1'b0, 1'b0);
        finish_op("ror");
        start_op(3'b000, 8'h80, 3'd1, 1'b1);
        wait_done("sll2", 0, lat(1));
        check_res("sll2", 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
        finish_op("sll2");

        // SRL 0xFF by 7 with flags disabled; stray start mid-op
        start_op(3'b001, 8'hFF, 3'd7, 1'b0);
`ifdef SHIFT_BARREL_EN
        wait_done("srl", 0, lat(7));
`else
        tick();
        tick();
        selop = 3'b000; din = 8'h00; shamt = 3'd1; enaf = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        check("srl ignored_start dout", dout, 8'h1F);
        wait_done("srl", 3, lat(7));
`endif
        check_res("srl", 8'h01, 1'b1, 1'b0, 1'b1, 1'b1);
        finish_op("srl");

        // ROL 0x81 by 7 (max shift, wraps)
        start_op(3'b011, 8'h81, 3'd7, 1'b1);
        wait_done("rol7", 0, lat(7));
        check_res("rol7", 8'hC0, 1'b0, 1'b1, 1'b1, 1'b0);
        finish_op("rol7");

        // shamt = 0: no step, done at edge 1
        start_op(3'b000, 8'h55, 3'd0, 1'b1);
        wait_done("sh0", 0, 1);
        check_res("sh0", 8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
        finish_op("sh0");

        // PASS mode ignores shamt
        start_op(3'b101, 8'h00, 3'd5, 1'b1);
        wait_done("pass", 0, 1);
        check_res("pass", 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        finish_op("pass");

        // reset mid-operation
        start_op(3'b000, 8'hFF, 3'd5, 1'b1);
        tick();
        rst = 1'b0;
        tick();
        check("midrst busy", {7'b0, busy}, 8'h00);
        check("midrst done", {7'b0, done}, 8'h00);
        check_res("midrst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;

        // new operation accepted after reset
        start_op(3'b001, 8'h80, 3'd1, 1'b1);
        wait_done("postrst", 0, lat(1));
        check_res("postrst", 8'h40, 1'b0, 1'b0, 1'b0, 1'b0);
        finish_op("postrst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
